// File: rtl/stop_watch_test_amisha.sv
// Stopwatch for a 4-digit multiplexed 7-segment board: 0.1 s tick, 3-digit BCD
// counter (00.0..99.9), segment decode and an active-low anode/segment scan.
module stop_watch_test_amisha #(
    parameter int DVSR         = 5_000_000,
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic [1:0] btn_amisha,
    output logic [3:0] an_amisha,
    output logic [7:0] sseg_amisha
);
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(DVSR - 1);

    logic                    clr, go, tick;
    logic [CW-1:0]           tick_q, tick_d;
    logic [3:0]              d0_q, d1_q, d2_q;
    logic [3:0]              d0_d, d1_d, d2_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              sel;
    logic [3:0]              hex;
    logic                    dp_n, blank;

    assign clr  = btn_amisha[0];
    assign go   = btn_amisha[1];
    assign tick = go && !clr && (tick_q == TICK_MAX);

    always_comb begin
        tick_d = tick_q;
        if (clr)
            tick_d = '0;
        else if (go)
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + CW'(1);
    end

    // Ripple carry through the three BCD digits; 99.9 rolls silently to 00.0.
    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        d2_d = d2_q;
        if (clr) begin
            d0_d = '0;
            d1_d = '0;
            d2_d = '0;
        end else if (tick) begin
            if (d0_q != 4'd9) begin
                d0_d = d0_q + 4'd1;
            end else begin
                d0_d = '0;
                if (d1_q != 4'd9) begin
                    d1_d = d1_q + 4'd1;
                end else begin
                    d1_d = '0;
                    d2_d = (d2_q != 4'd9) ? d2_q + 4'd1 : 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            tick_q    <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            refresh_q <= '0;
        end else begin
            tick_q    <= tick_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            refresh_q <= refresh_q + REFRESH_BITS'(1);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign sel = refresh_q[REFRESH_BITS-1:REFRESH_BITS-2];

    // The dp on the seconds digit renders the "xx.x" decimal point.
    always_comb begin
        an_amisha = 4'b1110;
        hex       = d0_q;
        dp_n      = 1'b1;
        blank     = 1'b0;
        case (sel)
            2'b00: begin an_amisha = 4'b1110; hex = d0_q; end
            2'b01: begin an_amisha = 4'b1101; hex = d1_q; dp_n = 1'b0; end
            2'b10: begin an_amisha = 4'b1011; hex = d2_q; end
            default: begin an_amisha = 4'b0111; blank = 1'b1; end
        endcase
    end

    assign sseg_amisha = blank ? 8'hFF : {dp_n, seg7(hex)};

endmodule

// File: tb/tb_stop_watch_test_amisha.sv
// Directed bench for the stopwatch: table of button/cycle vectors with the
// expected displayed digits, plus hand sequences for scan order and reset.
module tb_stop_watch_test_amisha;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;

    stop_watch_test_amisha #(.DVSR(4), .REFRESH_BITS(4)) dut (
        .clk_amisha(clk), .reset_amisha(rst), .btn_amisha(btn),
        .an_amisha(an), .sseg_amisha(sseg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] btn;
        int         cyc;
        int         d2, d1, d0;
        string      name;
    } vec_t;

    logic [6:0] SEG [10];
    logic [7:0] cap [4];
    logic [3:0] seen;
    vec_t       vt  [14];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scan one full refresh period with buttons released and capture each digit.
    task automatic read_display(input string nm);
        seen = 4'b0000;
        for (int i = 0; i < 4; i++) cap[i] = 8'hXX;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin cap[0] = sseg; seen[0] = 1'b1; end
                4'b1101: begin cap[1] = sseg; seen[1] = 1'b1; end
                4'b1011: begin cap[2] = sseg; seen[2] = 1'b1; end
                4'b0111: begin cap[3] = sseg; seen[3] = 1'b1; end
                default: begin
                    checks++; errors++;
                    $display("FAIL %s an_onehot: got %b", nm, an);
                end
            endcase
        end
        chk({nm, " an_coverage"}, {4'h0, seen}, 8'h0F);
    endtask

    task automatic check_disp(input string nm, input int d2, input int d1, input int d0);
        read_display(nm);
        chk({nm, " d0"},    cap[0], {1'b1, SEG[d0]});
        chk({nm, " d1"},    cap[1], {1'b0, SEG[d1]});
        chk({nm, " d2"},    cap[2], {1'b1, SEG[d2]});
        chk({nm, " blank"}, cap[3], 8'hFF);
    endtask

    task automatic apply(input logic [1:0] b, input int n);
        @(negedge clk);
        btn = b;
        repeat (n) @(posedge clk);
        #1 btn = 2'b00;
    endtask

    initial begin
        logic [3:0] exp_an;
        logic [7:0] exp_ss;
        int         s;

        SEG[0] = 7'h40; SEG[1] = 7'h79; SEG[2] = 7'h24; SEG[3] = 7'h30; SEG[4] = 7'h19;
        SEG[5] = 7'h12; SEG[6] = 7'h02; SEG[7] = 7'h78; SEG[8] = 7'h00; SEG[9] = 7'h10;

        vt[0]  = '{2'b01,    1, 0, 0, 0, "clear"};
        vt[1]  = '{2'b00,  100, 0, 0, 0, "idle100"};
        vt[2]  = '{2'b10,   40, 0, 1, 0, "go40"};
        vt[3]  = '{2'b10,   20, 0, 1, 5, "go20more"};
        vt[4]  = '{2'b01,    1, 0, 0, 0, "clear2"};
        vt[5]  = '{2'b10,   10, 0, 0, 2, "go10_partial"};
        vt[6]  = '{2'b00,   50, 0, 0, 2, "hold50"};
        vt[7]  = '{2'b10,    1, 0, 0, 2, "resume1"};
        vt[8]  = '{2'b10,    1, 0, 0, 3, "resume_tick"};
        vt[9]  = '{2'b11,    5, 0, 0, 0, "both_held"};
        vt[10] = '{2'b10,    4, 0, 0, 1, "go_first_tick"};
        vt[11] = '{2'b01,    1, 0, 0, 0, "clear3"};
        vt[12] = '{2'b10, 3996, 9, 9, 9, "go999"};
        vt[13] = '{2'b10,    4, 0, 0, 0, "wrap1000"};

        // Reset state and scan order from a known refresh count of zero.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", {4'h0, an}, 8'h0E);
        chk("reset_sseg", sseg, 8'hC0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s = (k >> 2) & 3;
            exp_an = (s == 0) ? 4'b1110 : (s == 1) ? 4'b1101 : (s == 2) ? 4'b1011 : 4'b0111;
            exp_ss = (s == 0) ? 8'hC0 : (s == 1) ? 8'h40 : (s == 2) ? 8'hC0 : 8'hFF;
            if (k % 2 == 0) begin
                chk($sformatf("scan_an_%0d", k), {4'h0, an}, {4'h0, exp_an});
                chk($sformatf("scan_sseg_%0d", k), sseg, exp_ss);
            end
            @(negedge clk);
        end

        for (int i = 0; i < 14; i++) begin
            apply(vt[i].btn, vt[i].cyc);
            check_disp(vt[i].name, vt[i].d2, vt[i].d1, vt[i].d0);
        end

        // Seconds digit with decimal point while showing 01.0.
        apply(2'b10, 40);
        read_display("dp_digit1");
        chk("dp_digit1 sseg", cap[1], 8'h79);

        // Clear for a single cycle mid-count also zeroes the tick counter.
        apply(2'b10, 6);
        apply(2'b01, 1);
        apply(2'b10, 3);
        check_disp("clear_tickcnt_3cyc", 0, 0, 0);
        apply(2'b10, 1);
        check_disp("clear_tickcnt_4cyc", 0, 0, 1);

        // Asynchronous reset between edges while counting.
        apply(2'b10, 30);
        @(negedge clk);
        btn = 2'b10;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_an", {4'h0, an}, 8'h0E);
        chk("async_rst_sseg", sseg, 8'hC0);
        @(negedge clk);
        btn = 2'b00;
        rst = 1'b0;
        check_disp("after_reset_idle", 0, 0, 0);
        apply(2'b10, 8);
        check_disp("after_reset_go", 0, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
